// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD to unsigned binary converter (reverse double dabble).
// Start/done/ack handshake; the result is held in DONE until acknowledged.
module bcd_to_binary #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ack,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS-1:0]   binary,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    ST_I      = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_ADJUST = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Digits >= 8 after a right shift carried a half-weight 10; subtracting 3 restores BCD.
  function automatic logic [W-1:0] adjust_digits(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      r[4*i +: 4] = (d >= 4'd8) ? (d - 4'd3) : d;
    end
    return r;
  endfunction

  state_t         state_r, state_s;
  logic [W-1:0]   dig_r, dig_s;
  logic [W-1:0]   acc_r, acc_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [W-1:0]   bin_s;
  logic           done_s, err_s, busy_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_s = state_r;
    dig_s   = dig_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    bin_s   = binary;
    done_s  = done;
    err_s   = err;
    busy_s  = busy;
    case (state_r)
      ST_I: begin
        done_s = 1'b0;
        busy_s = 1'b0;
        if (start) begin
          dig_s   = bcd;
          acc_s   = {W{1'b0}};
          cnt_s   = CW'(W);
          busy_s  = 1'b1;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_I;
        end
      end
      ST_LOAD: begin
        if (has_bad_digit(dig_r)) begin
          err_s   = 1'b1;
          bin_s   = {W{1'b0}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          err_s   = 1'b0;
          state_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        dig_s = {1'b0, dig_r[W-1:1]};
        acc_s = {dig_r[0], acc_r[W-1:1]};
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          bin_s   = {dig_r[0], acc_r[W-1:1]};
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_DONE;
        end else begin
          state_s = ST_ADJUST;
        end
      end
      ST_ADJUST: begin
        dig_s   = adjust_digits(dig_r);
        state_s = ST_SHIFT;
      end
      ST_DONE: begin
        done_s = 1'b1;
        if (ack) begin
          done_s  = 1'b0;
          state_s = ST_I;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        done_s  = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_I;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_I;
      dig_r   <= {W{1'b0}};
      acc_r   <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      binary  <= {W{1'b0}};
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      dig_r   <= dig_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      binary  <= bin_s;
      done    <= done_s;
      err     <= err_s;
      busy    <= busy_s;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: the driver queues expected results, a
// negedge monitor pops and compares on each rising done.
module tb_bcd_to_binary;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ack;
  logic [11:0] bcd;
  logic [11:0] binary;
  logic        done;
  logic        err;
  logic        busy;

  typedef struct {
    logic [11:0] bin;
    logic        err;
    int          sc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic done_q = 1'b0;

  bcd_to_binary #(.DIGITS(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ack    (ack),
    .bcd    (bcd),
    .binary (binary),
    .done   (done),
    .err    (err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each presented result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("binary", 32'(binary), 32'(e.bin));
        chk("err", 32'(err), 32'(e.err));
        chk("busy_in_done", 32'(busy), 32'(0));
        chk("latency", 32'(cyc - e.sc + 1), 32'(e.lat));
      end
    end
    done_q = done;
  end

  task automatic push(input logic [11:0] b, input logic e, input int sc);
    exp_t x;
    x.bin = b;
    x.err = e;
    x.sc  = sc;
    x.lat = e ? 2 : 25;
    sb.push_back(x);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      chk("done_timeout", 32'(0), 32'(1));
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("done_after_ack", 32'(done), 32'(0));
  endtask

  task automatic run(input logic [11:0] v, input logic [11:0] eb, input logic ee, input int hold);
    @(posedge clk); #1;
    bcd   = v;
    start = 1'b1;
    push(eb, ee, cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
    bcd   = 12'h000;
    wait_done();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_done", 32'(done), 32'(1));
      chk("hold_binary", 32'(binary), 32'(eb));
    end
    do_ack();
  endtask

  initial begin
    int off;
    int n;
    reset = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    bcd   = 12'h000;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_binary", 32'(binary), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    reset = 1'b1;

    // Maximum operand, held unacknowledged for 20 cycles.
    run(12'h999, 12'h3E7, 1'b0, 20);
    run(12'h000, 12'h000, 1'b0, 0);
    run(12'h109, 12'h06D, 1'b0, 0);

    // Invalid digit: early DONE with err set and zero result.
    run(12'h1A5, 12'h000, 1'b1, 3);
    chk("err_busy_low", 32'(busy), 32'(0));

    // Reset during conversion aborts without any result.
    @(posedge clk); #1;
    bcd   = 12'h999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_binary", 32'(binary), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_done_after_abort", 32'(done), 32'(0));
    run(12'h109, 12'h06D, 1'b0, 0);

    // Start/ack pulses during busy and bcd changes after capture are ignored.
    @(posedge clk); #1;
    bcd   = 12'h250;
    start = 1'b1;
    push(12'h0FA, 1'b0, cyc + 1);
    @(posedge clk); #1;
    start = 1'b0;
    bcd   = 12'h777;
    for (int p = 0; p < 5; p++) begin
      start = 1'b1;
      ack   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ack   = 1'b0;
      @(posedge clk); #1;
    end
    wait_done();
    do_ack();

    // Start held high: ack wins in DONE, next capture happens from I.
    @(posedge clk); #1;
    bcd   = 12'h250;
    start = 1'b1;
    push(12'h0FA, 1'b0, cyc + 1);
    @(posedge clk); #1;
    bcd   = 12'h321;
    wait_done();
    ack = 1'b1;
    push(12'h141, 1'b0, cyc + 2);
    @(posedge clk); #1;
    ack = 1'b0;
    chk("held_done_drop", 32'(done), 32'(0));
    @(posedge clk); #1;
    bcd = 12'h888;
    wait_done();
    start = 1'b0;
    do_ack();
    repeat (3) @(posedge clk);
    #1;
    chk("held_no_restart", 32'(busy), 32'(0));

    // Sweep of every valid 3-digit operand from a random offset.
    off = $urandom_range(999);
    for (int i = 0; i < 1000; i++) begin
      n = (i * 7 + off) % 1000;
      run({4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)}, 12'(n), 1'b0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Multi-cycle converter from packed BCD (DIGITS decimal digits) to unsigned binary, using reverse double dabble (shift right, then subtract 3 from any digit >= 8).
- It is the inverse companion of the binary-to-BCD display path. It serves keypad/switch-entered decimal operands before they reach the ALU datapath.
- Uses a start/done/ack handshake. A result is held until the consumer acknowledges it.

Parameters:
- DIGITS, 3, number of BCD digits. Input and output width W = 4*DIGITS. Shift count = W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  conversion request; sampled only in state I.
- ack  input  1  result acknowledge; sampled only in state DONE.
- bcd  input  W  packed BCD operand; digit 0 in [3:0]; captured on the edge where start is accepted.
- binary  output  W  registered result; zero-extended binary value.
- done  output  1  registered; high exactly while in DONE.
- err  output  1  registered; valid while done=1; 1 = some input digit > 9.
- busy  output  1  registered; high in LOAD, SHIFT, ADJUST.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=I; binary=0, done=0, err=0, busy=0.
  - Internal shift register and count cleared.
  - Reset mid-conversion aborts with no output update.
- Internal state: 2W-bit shift register {dig[W-1:0], acc[W-1:0]}; count 0..W.
- I:
  - done=0, busy=0.
  - If start=1: capture bcd into dig, clear acc, count<=W, go to LOAD.
  - binary/err keep their previous values.
- LOAD (1 cycle):
  - If any digit > 9: err<=1, binary<=0, busy<=0, done<=1, go to DONE.
  - Otherwise err<=0, go to SHIFT.
- SHIFT (1 cycle):
  - Shift the 2W register right by 1; count<=count-1.
  - If count==1 (last shift): binary<=shifted acc, done<=1, busy<=0, go to DONE.
  - Otherwise go to ADJUST.
- ADJUST (1 cycle):
  - Every 4-bit digit of dig that is >= 8 is replaced by digit-3, all digits in parallel.
  - Go to SHIFT.
- Sequence for a valid operand: LOAD, then W SHIFT states interleaved with W-1 ADJUST states.
- DONE:
  - done=1 and binary/err held stable.
  - On ack=1: done<=0, go to I.
  - Without ack the block stays in DONE indefinitely.
- Latency (edge 1 = edge sampling start=1):
  - Valid operand: done visible after edge 2W+1 (25 for DIGITS=3).
  - Invalid operand: done visible after edge 2.
- Boundary rules:
  - start outside I is ignored.
  - ack outside DONE is ignored.
  - start=1 together with ack=1 in DONE: ack is honoured and start is dropped; a new request must be presented in I.
  - start held high continuously: a new conversion begins the cycle after returning to I.
  - bcd changes after capture do not affect the running conversion.
  - Widths: the maximum input 10^DIGITS-1 always fits in W bits, so there is no overflow; upper unused bits of binary read 0.
  - ADJUST subtraction never underflows, because it is applied only to digits >= 8.

Test Plan:
- Reset with reset=0 mid-conversion (edge 10), release -> binary=0, done=0, busy=0, state I; the next start converts normally.
- bcd=0x999, start pulse -> done=1 after edge 25, binary=0x3E7, err=0; hold ack=0 for 20 cycles -> outputs stable; ack=1 -> done=0 next edge.
- bcd=0x000, then bcd=0x109 -> binary=0x000, then binary=0x06D; err=0 both.
- bcd=0x1A5 -> done=1 after edge 2, err=1, binary=0, busy never high after LOAD.
- start=1 held throughout with ack=1 in DONE: bcd=0x250 -> binary=0x0FA; the following conversion restarts from I with the newly captured bcd; start pulses during busy=1 are ignored (result unchanged).
- Randomised sweep of all 1000 valid 3-digit values vs. reference model -> exact match, constant 25-edge latency.
